// File: rtl/uart_pkg.sv
// Shared UART definitions: receive phase encoding, default frame geometry and line levels.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    FINISH
  } phase_t;

  localparam int unsigned CLKS_PER_BIT_DEF = 16;
  localparam int unsigned DATA_BITS_DEF    = 8;
  localparam logic        UART_IDLE_LEVEL  = 1'b1;

endpackage

// File: rtl/rx_baud_counter.sv
// Baud timing for the RX datapath: ticks at the half-bit point in half mode,
// otherwise at the end of each full bit period.
module rx_baud_counter
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic i_clear,
  input  logic i_half_mode,
  output logic o_tick
);

  localparam int unsigned CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL_LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] r_cnt;

  assign o_tick = (r_cnt == (i_half_mode ? HALF_LAST : FULL_LAST));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (i_clear || o_tick) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/datapath_rx.sv
// UART receive datapath: mid-bit sampling, LSB-first shift-in and stop-bit check,
// reporting frame completion to the RX controller and received words to the consumer.
module datapath_rx
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_DEF,
  parameter int unsigned DATA_BITS    = DATA_BITS_DEF
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 serial_in,
  input  logic                 en,
  output logic                 done_rx,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 data_valid,
  output logic                 frame_err
);

  localparam int unsigned BW = $clog2(DATA_BITS + 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);

  phase_t               r_phase;
  phase_t               w_phase_next;
  logic [BW-1:0]        r_bit_cnt;
  logic [DATA_BITS-1:0] r_shift;
  logic [DATA_BITS-1:0] r_data_out;
  logic                 r_done_rx;
  logic                 r_data_valid;
  logic                 r_frame_err;
  logic                 r_idle_hold;

  logic w_tick;
  logic w_clear;
  logic w_half_mode;
  logic w_shift_en;
  logic w_stop_sample;

  rx_baud_counter #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk        (clk),
    .reset      (reset),
    .i_clear    (w_clear),
    .i_half_mode(w_half_mode),
    .o_tick     (w_tick)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_phase <= IDLE;
    end else begin
      r_phase <= w_phase_next;
    end
  end

  always_comb begin
    w_phase_next = r_phase;
    case (r_phase)
      IDLE:    if (en && !r_idle_hold) w_phase_next = START;
      START: begin
        if (!en)         w_phase_next = IDLE;
        else if (w_tick) w_phase_next = (serial_in == UART_IDLE_LEVEL) ? FINISH : DATA;
      end
      DATA: begin
        if (!en)                                 w_phase_next = IDLE;
        else if (w_tick && r_bit_cnt == LAST_BIT) w_phase_next = STOP;
      end
      STOP: begin
        if (!en)         w_phase_next = IDLE;
        else if (w_tick) w_phase_next = FINISH;
      end
      FINISH:  w_phase_next = IDLE;
      default: w_phase_next = IDLE;
    endcase
  end

  // The baud counter keeps running from cycle 0 so the start sample lands on cycle H-1.
  always_comb begin
    w_clear       = 1'b1;
    w_half_mode   = 1'b0;
    w_shift_en    = 1'b0;
    w_stop_sample = 1'b0;
    case (r_phase)
      IDLE:  w_clear = !(en && !r_idle_hold);
      START: begin
        w_clear     = !en;
        w_half_mode = 1'b1;
      end
      DATA: begin
        w_clear    = !en;
        w_shift_en = en && w_tick;
      end
      STOP: begin
        w_clear       = !en;
        w_stop_sample = en && w_tick;
      end
      default: w_clear = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_bit_cnt    <= '0;
      r_shift      <= '0;
      r_data_out   <= '0;
      r_done_rx    <= 1'b0;
      r_data_valid <= 1'b0;
      r_frame_err  <= 1'b0;
      r_idle_hold  <= 1'b0;
    end else begin
      if (w_phase_next != DATA) begin
        r_bit_cnt <= '0;
      end else if (w_shift_en) begin
        r_bit_cnt <= r_bit_cnt + 1'b1;
      end
      if (w_shift_en) begin
        r_shift <= {serial_in, r_shift[DATA_BITS-1:1]};
      end
      if (w_stop_sample && serial_in == UART_IDLE_LEVEL) begin
        r_data_out <= r_shift;
      end
      r_data_valid <= w_stop_sample && (serial_in == UART_IDLE_LEVEL);
      r_frame_err  <= w_stop_sample && (serial_in != UART_IDLE_LEVEL);
      r_done_rx    <= (w_phase_next == FINISH);
      r_idle_hold  <= (r_phase == FINISH);
    end
  end

  assign done_rx    = r_done_rx;
  assign data_out   = r_data_out;
  assign data_valid = r_data_valid;
  assign frame_err  = r_frame_err;

endmodule

// File: tb/tb_datapath_rx.sv
// Directed bench for datapath_rx: default geometry instance plus an 8-clock-per-bit instance
// for back-to-back frames.
module tb_datapath_rx;
  import uart_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset;
  logic       s16, en16, done16, dv16, fe16;
  logic [7:0] do16;
  logic       s8, en8, done8, dv8, fe8;
  logic [7:0] do8;

  datapath_rx #(.CLKS_PER_BIT(16), .DATA_BITS(8)) dut16 (
    .clk(clk), .reset(reset), .serial_in(s16), .en(en16),
    .done_rx(done16), .data_out(do16), .data_valid(dv16), .frame_err(fe16)
  );

  datapath_rx #(.CLKS_PER_BIT(8), .DATA_BITS(8)) dut8 (
    .clk(clk), .reset(reset), .serial_in(s8), .en(en8),
    .done_rx(done8), .data_out(do8), .data_valid(dv8), .frame_err(fe8)
  );

  int n_total = 0;
  int n_bad   = 0;

  task automatic chk(input string tag, input int got, input int exp);
    n_total++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  // Drives one frame on dut16 starting at cycle 0 with a controller model that drops en
  // the cycle after done_rx; optional glitch, mid-frame en drop or mid-frame reset.
  task automatic run16(input logic [7:0] d, input logic stopb, input bit glitch,
                       input int drop_at, input int rst_at,
                       output int done_cyc, output int n_done, output int dv_cyc,
                       output int n_dv, output int n_fe, output int ph9);
    int  k;
    bit  killed;
    done_cyc = -1; n_done = 0; dv_cyc = -1; n_dv = 0; n_fe = 0; ph9 = -1; killed = 0;
    for (int c = 0; c < 170; c++) begin
      if (done16) begin n_done++; if (done_cyc < 0) done_cyc = c; end
      if (dv16)   begin n_dv++;   if (dv_cyc < 0)   dv_cyc = c;   end
      if (fe16)   n_fe++;
      if (c == 9) ph9 = int'(dut16.r_phase);
      reset = 1'b0;
      if (c == rst_at) begin
        reset  = 1'b1;
        killed = 1'b1;
        #1;
        chk("rst_mid_dout", int'(do16), 0);
        chk("rst_mid_done", int'(done16), 0);
        chk("rst_mid_dv", int'(dv16), 0);
        chk("rst_mid_fe", int'(fe16), 0);
      end
      k = c / 16;
      if (glitch)      s16 = (c < 3) ? 1'b0 : 1'b1;
      else if (k == 0) s16 = 1'b0;
      else if (k <= 8) s16 = d[k-1];
      else if (k == 9) s16 = stopb;
      else             s16 = 1'b1;
      if (killed) s16 = 1'b1;
      en16 = !killed && (drop_at < 0 || c < drop_at) && (done_cyc < 0 || c == done_cyc);
      step;
    end
    en16  = 1'b0;
    s16   = 1'b1;
    reset = 1'b0;
  endtask

  // Two frames 0x55, 0xAA on dut8: 10-bit frame plus one idle bit, so starts 88 cycles apart.
  task automatic run8;
    logic [7:0] b8 [2];
    int         d8done [2];
    int         dvc [2];
    int         dvv [2];
    int         ndv8, nfe8, f, rel, k;
    logic [7:0] cur;
    b8[0] = 8'h55; b8[1] = 8'hAA;
    d8done[0] = -1; d8done[1] = -1;
    dvc[0] = -1; dvc[1] = -1; dvv[0] = -1; dvv[1] = -1;
    ndv8 = 0; nfe8 = 0;
    for (int c = 0; c < 200; c++) begin
      f = (c >= 88) ? 1 : 0;
      if (done8 && d8done[f] < 0) d8done[f] = c;
      if (dv8) begin
        if (ndv8 < 2) begin dvc[ndv8] = c; dvv[ndv8] = int'(do8); end
        ndv8++;
      end
      if (fe8) nfe8++;
      rel = c - 88 * f;
      k   = rel / 8;
      cur = b8[f];
      if (k == 0)      s8 = 1'b0;
      else if (k <= 8) s8 = cur[k-1];
      else             s8 = 1'b1;
      en8 = (d8done[f] < 0) || (c == d8done[f]);
      step;
    end
    en8 = 1'b0;
    s8  = 1'b1;
    chk("b2b_dv_count", ndv8, 2);
    chk("b2b_fe_count", nfe8, 0);
    chk("b2b_dv0_cycle", dvc[0], 76);
    chk("b2b_dv0_data", dvv[0], 'h55);
    chk("b2b_dv1_cycle", dvc[1], 164);
    chk("b2b_dv1_data", dvv[1], 'hAA);
    chk("b2b_spacing", dvc[1] - dvc[0], 88);
  endtask

  int dc, nd, dvc, ndv, nfe, ph;

  initial begin
    reset = 1'b1;
    s16 = 1'b1; en16 = 1'b0;
    s8  = 1'b1; en8  = 1'b0;
    repeat (3) step;
    chk("rst_dout", int'(do16), 0);
    chk("rst_done", int'(done16), 0);
    chk("rst_dv", int'(dv16), 0);
    chk("rst_fe", int'(fe16), 0);
    reset = 1'b0;
    repeat (2) step;

    run16(8'hA5, 1'b1, 1'b0, -1, -1, dc, nd, dvc, ndv, nfe, ph);
    chk("a5_done_cycle", dc, 152);
    chk("a5_done_count", nd, 1);
    chk("a5_dv_cycle", dvc, 152);
    chk("a5_dv_count", ndv, 1);
    chk("a5_fe_count", nfe, 0);
    chk("a5_data", int'(do16), 'hA5);

    run16(8'h3C, 1'b0, 1'b0, -1, -1, dc, nd, dvc, ndv, nfe, ph);
    chk("ferr_done_cycle", dc, 152);
    chk("ferr_done_count", nd, 1);
    chk("ferr_fe_count", nfe, 1);
    chk("ferr_dv_count", ndv, 0);
    chk("ferr_data_held", int'(do16), 'hA5);

    run16(8'h00, 1'b1, 1'b1, -1, -1, dc, nd, dvc, ndv, nfe, ph);
    chk("glitch_done_cycle", dc, 8);
    chk("glitch_done_count", nd, 1);
    chk("glitch_dv_count", ndv, 0);
    chk("glitch_fe_count", nfe, 0);
    chk("glitch_phase_c9", ph, int'(IDLE));

    run16(8'hFF, 1'b1, 1'b0, -1, 60, dc, nd, dvc, ndv, nfe, ph);
    chk("rstf_done_count", nd, 0);
    chk("rstf_dv_count", ndv, 0);
    run16(8'h01, 1'b1, 1'b0, -1, -1, dc, nd, dvc, ndv, nfe, ph);
    chk("x01_dv_cycle", dvc, 152);
    chk("x01_data", int'(do16), 'h01);

    run16(8'h5A, 1'b1, 1'b0, 70, -1, dc, nd, dvc, ndv, nfe, ph);
    chk("drop_done_count", nd, 0);
    chk("drop_dv_count", ndv, 0);
    chk("drop_fe_count", nfe, 0);
    chk("drop_data_held", int'(do16), 'h01);
    run16(8'h80, 1'b1, 1'b0, -1, -1, dc, nd, dvc, ndv, nfe, ph);
    chk("x80_dv_cycle", dvc, 152);
    chk("x80_dv_count", ndv, 1);
    chk("x80_data", int'(do16), 'h80);

    run8;

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
